// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: STAGES-rank pipelined add/sub with valid/ready backpressure, carry-out and signed overflow
module pipelined_carry_adder #(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;
  if (WIDTH % STAGES != 0) begin : g_bad
    $error("WIDTH must be a multiple of STAGES");
  end
  logic en;
  logic [STAGES:0] v, c, o;
  logic [STAGES:0][WIDTH-1:0] av, bv, sv;
  logic unused_skew;
  assign en = ~out_valid | out_ready;
  assign in_ready = en;
  assign v[0] = in_valid;
  assign c[0] = op_sub | cin;
  assign o[0] = 1'b0;
  assign av[0] = a;
  assign bv[0] = op_sub ? ~b : b;
  assign sv[0] = '0;
  for (genvar i = 0; i < STAGES; i++) begin : g_rank
    logic [CHUNK:0] t;
    logic m, vr, cr, ovr;
    logic [WIDTH-1:0] ar, br, sr;
    assign t = {1'b0, av[i][i*CHUNK +: CHUNK]} + {1'b0, bv[i][i*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c[i]};
    assign m = t[CHUNK-1] ^ av[i][(i+1)*CHUNK-1] ^ bv[i][(i+1)*CHUNK-1];
    always_ff @(posedge clk)
      if (rst) begin
        vr <= 1'b0;
        cr <= 1'b0;
        ovr <= 1'b0;
        sr <= '0;
      end else if (en) begin
        vr <= v[i];
        cr <= t[CHUNK];
        ovr <= (i == STAGES - 1) ? m ^ t[CHUNK] : o[i];
        ar <= av[i];
        br <= bv[i];
        sr <= sv[i] | (WIDTH'(t[CHUNK-1:0]) << (i * CHUNK));
      end
    assign v[i+1] = vr;
    assign c[i+1] = cr;
    assign o[i+1] = ovr;
    assign av[i+1] = ar;
    assign bv[i+1] = br;
    assign sv[i+1] = sr;
  end
  assign unused_skew = ^{av[STAGES], bv[STAGES]};
  assign out_valid = v[STAGES];
  assign sum = sv[STAGES];
  assign cout = c[STAGES];
  assign ovf = o[STAGES];
endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
Parametrised, pipelined N-bit adder/subtractor, the successor to the single-cycle ripple-carry adder. Operands split into STAGES equal chunks; each pipeline rank ripples one chunk and registers its carry into the next rank, with skew/deskew registers keeping operand and sum slices aligned. Adds a valid/ready handshake with backpressure, a subtract mode, and signed-overflow detection. Used wherever wide adds must close timing at full clock rate in the datapath.

Parameters:
WIDTH, 16, operand/sum width in bits; WIDTH >= 1
STAGES, 4, pipeline ranks = carry-chain segments; WIDTH % STAGES == 0 required (elaboration-time $error otherwise); STAGES >= 1
CHUNK, WIDTH/STAGES, derived localparam, bits added per rank (not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A (unsigned/two's complement)
b  input  WIDTH  operand B
cin  input  1  carry-in; used only when op_sub=0
op_sub  input  1  0: a+b+cin; 1: a-b (cin ignored)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out; in sub mode 1 = no borrow (a >= b unsigned)
ovf  output  1  signed overflow flag

Behaviour:
- Reset (rst high at clk edge): all rank valid bits, out_valid, sum, cout, ovf -> 0; in-flight beats discarded; in_ready = 1 in the cycle after reset. rst takes priority over any simultaneous handshake.
- Transfer: input beat accepted when in_valid & in_ready at a clk edge; output consumed when out_valid & out_ready.
- Global enable: en = ~out_valid | out_ready. in_ready = en (combinational). All ranks advance together when en=1, hold all data and valid bits when en=0. Bubbles (rank valid=0) propagate like data; no bubble-collapsing.
- Sub mode: b_eff = ~b, carry-in = 1; add mode: b_eff = b, carry-in = cin. op_sub is captured at acceptance and travels with the beat.
- Rank i (0..STAGES-1) computes bits [i*CHUNK +: CHUNK] = a_chunk + b_eff_chunk + carry from rank i-1 (rank 0 uses carry-in), registers chunk sum and carry-out. Upper operand chunks delayed through skew registers; lower sum chunks delayed through deskew registers so the full sum emerges aligned.
- Latency: beat accepted at edge k appears with out_valid=1 after edge k+STAGES-1 (STAGES=1: outputs registered one cycle after acceptance). Throughput 1 beat/cycle while out_ready=1.
- cout = carry out of the MSB of the top chunk. ovf = carry into MSB XOR carry out of MSB (equivalently sign(a)==sign(b_eff) && sign(sum)!=sign(a)).
- Arithmetic modulo 2^WIDTH; no saturation.
- Outputs stable while out_valid=1 and out_ready=0; no beat dropped or duplicated under any out_ready pattern.
- in_valid=0 with en=1 inserts a bubble; out_valid may go low between results.
- Inputs a, b, cin, op_sub ignored when in_valid=0.
- rst high mid-stream: all ranks flushed on that edge; results accepted before reset never appear.

Test Plan:
(WIDTH=16, STAGES=4 unless noted)
1. Add carry-chain: a=0xFFFF, b=0x0001, cin=0, op_sub=0, out_ready=1 -> after 4 cycles sum=0x0000, cout=1, ovf=0; a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
2. Signed overflow: a=0x7FFF+b=0x0001 -> sum=0x8000, cout=0, ovf=1; a=0x8000+b=0x8000 -> sum=0x0000, cout=1, ovf=1.
3. Subtract: 0x0003-0x0005 (cin=1 ignored) -> sum=0xFFFE, cout=0, ovf=0; 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
4. Backpressure: stream 8 beats a=i, b=0x0100 back-to-back; hold out_ready=0 for cycles 5-8 -> in_ready=0 while out_valid & ~out_ready, sum holds stable, all 8 results 0x0100+i emerge in order, none lost or duplicated.
5. Reset mid-flight: 3 beats in pipeline, pulse rst one cycle -> out_valid=0 on next cycle, none of the 3 results ever appear, in_ready=1 after reset; new beat 0x1234+0x1111 -> 0x2345 four cycles later.
6. Random regression (10k beats, random in_valid/out_ready, configs WIDTH/STAGES = 16/4, 8/1, 32/8, 12/3) vs golden {cout,sum} = a + b_eff + carry-in and ovf model -> zero mismatches, 1 beat/cycle when out_ready held high.
